firebird7_in_gate1_tessent_data_mux_ctrl: RTL and testbench
===========================================================

# firebird7_in_gate1_tessent_data_mux_ctrl

IJTAG-controlled takeover sequencer for the 3-bit gate1 data mux. A small TDR, accessed through the IJTAG network, holds a takeover-enable bit and the override data. A handshake FSM asks the functional side to quiesce, waits a programmable settle time, and only then drives the mux select. On release it drops the select and drains before handing control back.

## Interface
- WIDTH, default 3: data path width; matches the mux width.
- SETTLE_CYCLES, default 4: settle/drain length in tck cycles; legal range ≥1.
- ijtag_tck, input, 1: IJTAG clock; all state is on its rising edge.
- ijtag_reset, input, 1: asynchronous, active-high reset.
- ijtag_sel, input, 1: TDR selected on the scan path; gates ce/se/ue.
- ijtag_ce, input, 1: capture enable.
- ijtag_se, input, 1: shift enable.
- ijtag_ue, input, 1: update enable.
- ijtag_si, input, 1: scan in.
- ijtag_so, output, 1: scan out; equals shift_reg[0].
- functional_data_in, input, WIDTH: functional-side data, observed at capture.
- func_idle, input, 1: functional side acknowledges it is quiescent.
- takeover_req, output, 1: request to the functional side to quiesce.
- ijtag_select, output, 1: drives the mux select.
- ijtag_data_out, output, WIDTH: drives the mux ijtag_data_in.

## Operation
- TDR: shift_reg and update_reg are WIDTH+1 bits each. Bit WIDTH is EN; bits WIDTH-1:0 are DATA.
- Capture (sel&ce): shift_reg <= {ijtag_select, functional_data_in}.
- Shift (sel&se): shift_reg <= {ijtag_si, shift_reg[WIDTH:1]}. Shifting is LSB-first out.
- Update (sel&ue): update_reg <= shift_reg.
- Priority when more than one enable is active: capture, then shift, then update. With sel=0, nothing changes.
- ijtag_data_out = update_reg DATA. It is registered, so it changes only on an update edge, in any FSM state.
- FSM states and the outputs driven in each:
  - IDLE: req=0, select=0.
  - REQ: req=1, select=0.
  - SETTLE: req=1, select=0.
  - ACTIVE: req=1, select=1.
  - DRAIN: req=1, select=0.
- Outputs are decoded from registered state only; there are no combinational paths from inputs.
- Transitions:
  - IDLE -> REQ when EN=1.
  - REQ -> IDLE when EN=0 (abort).
  - REQ -> SETTLE when func_idle=1. The counter loads SETTLE_CYCLES-1.
  - SETTLE -> IDLE when EN=0.
  - SETTLE -> REQ when func_idle=0 (handshake lost; counter is reloaded on the next entry). This has lower priority than EN=0.
  - SETTLE -> ACTIVE when counter==0 and func_idle=1. Otherwise the counter decrements.
  - ACTIVE -> DRAIN when EN=0. The counter loads SETTLE_CYCLES-1. func_idle is ignored in ACTIVE.
  - DRAIN -> IDLE when counter==0. Otherwise the counter decrements. EN is ignored in DRAIN, so a re-enable is honoured from IDLE afterwards.
- Counter width is $clog2(SETTLE_CYCLES)+1. The counter never wraps; it is only decremented while nonzero.

## Timing
- Reset (async assert): all outputs read 0 immediately, including ijtag_so. State=IDLE; shift_reg, update_reg and counter are 0.
- Reset mid-ACTIVE drops ijtag_select asynchronously; no drain is performed.
- Let update edge = E0, with EN=1 and func_idle held 1:
  - E1: REQ; takeover_req=1.
  - E2: SETTLE.
  - E2+SETTLE_CYCLES: ACTIVE; select=1.
  - With SETTLE_CYCLES=4, select rises at E6.
- Release, with EN=0 updated at E0:
  - E1: DRAIN; select=0.
  - E1+SETTLE_CYCLES: IDLE; req=0.
- ijtag_data_out follows the update edge with 1-cycle register latency. It is valid before select rises because SETTLE is at least 1 cycle.
- ijtag_so changes on the edge after the capture or shift.

## Test plan
- Reset, then shift {EN=1, DATA=3'b101} (4 bits, si order 1,0,1,1) and update, with func_idle=1 -> data_out=3'b101 at E1; req=1 at E1; select=1 exactly at E6; select is never 1 before E6.
- func_idle=0 during REQ for 10 cycles, then 1 -> stays in REQ with select=0. Settle starts when func_idle rises; select rises SETTLE_CYCLES+1 edges after that.
- func_idle falls at SETTLE cycle 2 -> returns to REQ. When func_idle returns, a full 4-cycle settle is repeated with a reloaded counter.
- In ACTIVE, update DATA=3'b010 then EN=0 -> data_out=010 with select=1; then select=0 one edge after the EN=0 update; req=0 after 4 more edges; IDLE.
- Capture in ACTIVE with functional_data_in=3'b110, then shift 4 -> so sequence 0,1,1,1 (LSB first, EN last). Assert ijtag_reset mid-ACTIVE -> select, req, data_out and so are 0 asynchronously.
- Simultaneous ce+se+ue with sel=1 -> capture wins and update_reg is unchanged. With sel=0 and ue=1 -> no update occurs.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Purpose : IJTAG TDR plus handshake FSM that takes over the gate1 data mux (quiesce, settle, select, drain).
// Latency : data_out 1 tck after the update edge; select rises SETTLE_CYCLES+2 tck after an EN=1 update with func_idle held.
// Backpressure: func_idle is the only flow control; the FSM waits in REQ/SETTLE until the functional side reports quiescent.
//
// Ports:
//   ijtag_tck / ijtag_reset        : IJTAG clock, async active-high reset
//   ijtag_sel/ce/se/ue/si, ijtag_so: TDR access (capture/shift/update, scan in/out)
//   functional_data_in             : functional data observed at capture
//   func_idle                      : functional side quiescent acknowledge
//   takeover_req, ijtag_select     : handshake request and mux select (registered)
//   ijtag_data_out                 : override data to the mux (registered)
module firebird7_in_gate1_tessent_data_mux_ctrl #(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    input  logic             func_idle,
    output logic             takeover_req,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out
);

    localparam int            CW       = $clog2(SETTLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_SETTLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           req_q;
    logic           select_q;
    logic [WIDTH:0] shift_q;
    logic [WIDTH:0] shift_d;
    logic [WIDTH:0] update_q;
    logic [WIDTH:0] update_d;
    logic           en;

    assign en = update_q[WIDTH];

    // TDR next state. Enables are mutually exclusive by priority:
    // capture beats shift beats update, so a combined ce+ue never updates.
    always_comb begin
        shift_d  = shift_q;
        update_d = update_q;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                shift_d = {select_q, functional_data_in};
            end else if (ijtag_se) begin
                shift_d = {ijtag_si, shift_q[WIDTH:1]};
            end else if (ijtag_ue) begin
                update_d = shift_q;
            end
        end
    end

    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            shift_q  <= '0;
            update_q <= '0;
        end else begin
            shift_q  <= shift_d;
            update_q <= update_d;
        end
    end

    // Handshake FSM. req/select are registered alongside the state so the
    // mux select never sees a combinational path from func_idle or the TDR.
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            select_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (!en) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                    end else if (func_idle) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                S_SETTLE: begin
                    // Abort beats handshake loss; a lost handshake restarts
                    // the full settle on the next REQ->SETTLE entry.
                    if (!en) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                    end else if (!func_idle) begin
                        state_q <= S_REQ;
                    end else if (cnt_q == '0) begin
                        state_q  <= S_ACTIVE;
                        select_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_ACTIVE: begin
                    if (!en) begin
                        state_q  <= S_DRAIN;
                        select_q <= 1'b0;
                        cnt_q    <= CNT_LOAD;
                    end
                end
                S_DRAIN: begin
                    // EN is deliberately ignored here; a re-enable is picked
                    // up from IDLE once the drain completes.
                    if (cnt_q == '0) begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    req_q    <= 1'b0;
                    select_q <= 1'b0;
                end
            endcase
        end
    end

    assign ijtag_so       = shift_q[0];
    assign ijtag_data_out = update_q[WIDTH-1:0];
    assign takeover_req   = req_q;
    assign ijtag_select   = select_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_ctrl.sv
// Purpose : bench for the gate1 data mux takeover sequencer; directed scenarios then random traffic.
// Latency : outputs are sampled 1 time unit after each rising tck edge.
// Backpressure: func_idle is driven directly by the bench.
module tb_firebird7_in_gate1_tessent_data_mux_ctrl;

    localparam int W  = 3;
    localparam int SC = 4;

    // Behavioural phases of the takeover handshake.
    localparam int PH_IDLE   = 0;
    localparam int PH_REQ    = 1;
    localparam int PH_SETTLE = 2;
    localparam int PH_ACTIVE = 3;
    localparam int PH_DRAIN  = 4;

    logic         ijtag_tck;
    logic         ijtag_reset;
    logic         ijtag_sel;
    logic         ijtag_ce;
    logic         ijtag_se;
    logic         ijtag_ue;
    logic         ijtag_si;
    logic         ijtag_so;
    logic [W-1:0] functional_data_in;
    logic         func_idle;
    logic         takeover_req;
    logic         ijtag_select;
    logic [W-1:0] ijtag_data_out;

    int cmp_cnt;
    int err_cnt;

    // Reference model state.
    logic [W:0] m_sh;
    logic [W:0] m_upd;
    int         m_ph;
    int         m_t;   // edges already spent in the current SETTLE/DRAIN phase

    firebird7_in_gate1_tessent_data_mux_ctrl #(
        .WIDTH         (W),
        .SETTLE_CYCLES (SC)
    ) dut (
        .ijtag_tck          (ijtag_tck),
        .ijtag_reset        (ijtag_reset),
        .ijtag_sel          (ijtag_sel),
        .ijtag_ce           (ijtag_ce),
        .ijtag_se           (ijtag_se),
        .ijtag_ue           (ijtag_ue),
        .ijtag_si           (ijtag_si),
        .ijtag_so           (ijtag_so),
        .functional_data_in (functional_data_in),
        .func_idle          (func_idle),
        .takeover_req       (takeover_req),
        .ijtag_select       (ijtag_select),
        .ijtag_data_out     (ijtag_data_out)
    );

    initial ijtag_tck = 1'b0;
    always #5 ijtag_tck = ~ijtag_tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sh  = '0;
        m_upd = '0;
        m_ph  = PH_IDLE;
        m_t   = 0;
    endtask

    task automatic check_model();
        chk("model_req",  {31'd0, takeover_req}, {31'd0, (m_ph != PH_IDLE)});
        chk("model_sel",  {31'd0, ijtag_select}, {31'd0, (m_ph == PH_ACTIVE)});
        chk("model_data", {29'd0, ijtag_data_out}, {29'd0, m_upd[W-1:0]});
        chk("model_so",   {31'd0, ijtag_so}, {31'd0, m_sh[0]});
    endtask

    // One tck edge: advance the model from pre-edge values, then compare.
    task automatic tick();
        logic [W:0] nsh;
        logic [W:0] nupd;
        int         nph;
        int         nt;
        logic       en;
        nsh  = m_sh;
        nupd = m_upd;
        nph  = m_ph;
        nt   = m_t;
        en   = m_upd[W];
        if (ijtag_sel) begin
            if (ijtag_ce)
                nsh = {(m_ph == PH_ACTIVE), functional_data_in};
            else if (ijtag_se)
                nsh = (m_sh >> 1) | ((W+1)'(ijtag_si) << W);
            else if (ijtag_ue)
                nupd = m_sh;
        end
        case (m_ph)
            PH_IDLE:   if (en) nph = PH_REQ;
            PH_REQ:    if (!en) nph = PH_IDLE;
                       else if (func_idle) begin nph = PH_SETTLE; nt = 0; end
            PH_SETTLE: if (!en) nph = PH_IDLE;
                       else if (!func_idle) nph = PH_REQ;
                       else if (m_t + 1 >= SC) nph = PH_ACTIVE;
                       else nt = m_t + 1;
            PH_ACTIVE: if (!en) begin nph = PH_DRAIN; nt = 0; end
            default:   if (m_t + 1 >= SC) nph = PH_IDLE;
                       else nt = m_t + 1;
        endcase
        @(posedge ijtag_tck);
        #1;
        m_sh  = nsh;
        m_upd = nupd;
        m_ph  = nph;
        m_t   = nt;
        check_model();
    endtask

    task automatic drive(input logic sel, input logic ce, input logic se, input logic ue, input logic si);
        ijtag_sel = sel;
        ijtag_ce  = ce;
        ijtag_se  = se;
        ijtag_ue  = ue;
        ijtag_si  = si;
    endtask

    // Shift {en,d} LSB first, then update; the update edge is the last tick.
    task automatic load_tdr(input logic en, input logic [W-1:0] d);
        logic [W:0] v;
        v = {en, d};
        for (int i = 0; i <= W; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, v[i]);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cmp_cnt = 0;
        err_cnt = 0;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        functional_data_in = '0;
        func_idle          = 1'b0;
        ijtag_reset        = 1'b1;

        // Reset state
        #2;
        chk("rst_req",  {31'd0, takeover_req}, 32'd0);
        chk("rst_sel",  {31'd0, ijtag_select}, 32'd0);
        chk("rst_data", {29'd0, ijtag_data_out}, 32'd0);
        chk("rst_so",   {31'd0, ijtag_so}, 32'd0);
        #10;
        ijtag_reset = 1'b0;
        tick();

        // Basic takeover: select exactly at E6
        func_idle = 1'b1;
        load_tdr(1'b1, 3'b101);
        chk("e0_req", {31'd0, takeover_req}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("take_req", {31'd0, takeover_req}, 32'd1);
            chk("take_sel", {31'd0, ijtag_select}, {31'd0, (k >= 6)});
            if (k == 1) chk("take_data", {29'd0, ijtag_data_out}, 32'h5);
        end

        // New data while ACTIVE, then release and drain
        load_tdr(1'b1, 3'b010);
        chk("act_data", {29'd0, ijtag_data_out}, 32'h2);
        chk("act_sel",  {31'd0, ijtag_select}, 32'd1);
        load_tdr(1'b0, 3'b010);
        chk("rel_e0_sel", {31'd0, ijtag_select}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("drain_sel", {31'd0, ijtag_select}, 32'd0);
            chk("drain_req", {31'd0, takeover_req}, {31'd0, (k < 5)});
        end

        // func_idle held low in REQ
        func_idle = 1'b0;
        load_tdr(1'b1, 3'b111);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("wait_req", {31'd0, takeover_req}, 32'd1);
            chk("wait_sel", {31'd0, ijtag_select}, 32'd0);
        end
        func_idle = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("late_sel", {31'd0, ijtag_select}, {31'd0, (k == 5)});
        end

        // Handshake lost during SETTLE restarts a full settle
        load_tdr(1'b0, 3'b000);
        for (int k = 1; k <= 5; k++) tick();
        load_tdr(1'b1, 3'b011);
        tick();                 // E1 REQ
        tick();                 // E2 SETTLE
        tick();                 // E3 settle cycle
        func_idle = 1'b0;
        tick();                 // back to REQ
        chk("lost_req", {31'd0, takeover_req}, 32'd1);
        tick();
        tick();
        func_idle = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("resettle_sel", {31'd0, ijtag_select}, {31'd0, (k == 5)});
        end

        // Capture in ACTIVE and shift out LSB first
        functional_data_in = 3'b110;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("cap_so0", {31'd0, ijtag_so}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            if (k <= 3) chk("cap_so", {31'd0, ijtag_so}, 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Async reset mid-ACTIVE
        ijtag_reset = 1'b1;
        #1;
        chk("arst_sel",  {31'd0, ijtag_select}, 32'd0);
        chk("arst_req",  {31'd0, takeover_req}, 32'd0);
        chk("arst_data", {29'd0, ijtag_data_out}, 32'd0);
        chk("arst_so",   {31'd0, ijtag_so}, 32'd0);
        model_reset();
        #3;
        ijtag_reset = 1'b0;
        tick();

        // Enable priority and sel gating
        func_idle = 1'b0;
        load_tdr(1'b0, 3'b011);
        functional_data_in = 3'b100;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        chk("prio_data", {29'd0, ijtag_data_out}, 32'h3);
        chk("prio_so",   {31'd0, ijtag_so}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("nosel_data", {29'd0, ijtag_data_out}, 32'h3);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            ijtag_sel          = ($urandom_range(0, 3) != 0);
            ijtag_ce           = ($urandom_range(0, 7) == 0);
            ijtag_se           = ($urandom_range(0, 1) == 0);
            ijtag_ue           = ($urandom_range(0, 5) == 0);
            ijtag_si           = $urandom_range(0, 1) == 1;
            functional_data_in = W'($urandom);
            if ($urandom_range(0, 7) == 0) func_idle = ~func_idle;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
